// File: rtl/serial_sub_unit.sv
// serial_sub_unit
//   Bit-serial unsigned subtractor. It computes a - b LSB-first, one bit per
//   clock. Each bit passes through a full-subtract slice, which is two chained
//   half-subtract stages plus a registered borrow.
//
// Ports
//   clk        : system clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin an operation; sampled only while idle
//   a, b       : minuend / subtrahend; captured on the accepted start edge
//   busy       : high while an operation is shifting or signalling done
//   done       : one-cycle pulse; diff/borrow_out hold the new result
//   diff       : (a - b) mod 2^WIDTH; holds until the next completion
//   borrow_out : final borrow; 1 when a < b (unsigned)
module serial_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full subtractor built from two half-subtract stages.
  // The return value is {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d1;
    logic b1;
    logic d;
    logic b2;
    d1 = x ^ y;
    b1 = ~x & y;
    d  = d1 ^ bin;
    b2 = ~d1 & bin;
    return {b1 | b2, d};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_nxt_s;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         slice_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_out_r;

  // Current bit slice, and the result register after this bit is shifted in at the MSB.
  always_comb begin
    slice_s   = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
    res_nxt_s = {slice_s[0], res_r[WIDTH-1:1]};
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register. busy/done are registered from the next state, so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Datapath: load operands, shift one bit per edge, publish the result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r       <= {WIDTH{1'b0}};
      b_sh_r       <= {WIDTH{1'b0}};
      res_r        <= {WIDTH{1'b0}};
      borrow_r     <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_r    <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_r    <= res_nxt_s;
          borrow_r <= slice_s[1];
          cnt_r    <= cnt_r + CNT_W'(1);
          // The result register is published together with the bit that is
          // being computed on this edge.
          if (cnt_r == LAST_CNT) begin
            diff_r       <= res_nxt_s;
            borrow_out_r <= slice_s[1];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Scoreboard bench for serial_sub_unit. It uses one 8-bit instance and one
// 2-bit instance. Stimulus tasks push the expected results. Monitors sample on
// the falling edge and pop an entry on every done pulse.
module tb_serial_sub_unit;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         k;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bo8;
  logic       start2 = 1'b0;
  logic [1:0] a2 = 2'd0;
  logic [1:0] b2 = 2'd0;
  logic       busy2;
  logic       done2;
  logic [1:0] diff2;
  logic       bo2;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q8[$];
  exp_t q2[$];
  exp_t e8;
  exp_t e2;
  logic [7:0] last_d8 = 8'h00;
  logic       last_b8 = 1'b0;

  serial_sub_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_sub_unit #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 8-bit monitor
  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'(q8.size()), 32'd1);
      end else begin
        e8 = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e8.d));
        chk("borrow8", 32'(bo8), 32'(e8.bo));
        chk("latency8", 32'(cyc), 32'(e8.k + 8));
        chk("busy8_in_done", 32'(busy8), 32'd1);
      end
    end
  end

  // 2-bit monitor
  always @(negedge clk) begin
    if (rst_n && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("done2_unexpected", 32'(q2.size()), 32'd1);
      end else begin
        e2 = q2.pop_front();
        chk("diff2", 32'(diff2), 32'(e2.d));
        chk("borrow2", 32'(bo2), 32'(e2.bo));
        chk("latency2", 32'(cyc), 32'(e2.k + 2));
      end
    end
  end

  // One full 8-bit operation. The previous result must hold while shifting.
  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    @(posedge clk);
    #1;
    q8.push_back('{d: ed, bo: eb, k: cyc});
    start8 = 1'b0;
    a8 = ~a;
    b8 = ~b;
    chk("busy8_after_accept", 32'(busy8), 32'd1);
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk);
      #1;
      chk("diff8_hold", 32'(diff8), 32'(last_d8));
      chk("borrow8_hold", 32'(bo8), 32'(last_b8));
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("busy8_idle", 32'(busy8), 32'd0);
    chk("done8_seen", 32'(q8.size()), 32'd0);
    q8.delete();
    last_d8 = ed;
    last_b8 = eb;
  endtask

  task automatic go2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] ed;
    ed = a - b;
    start2 = 1'b1;
    a2 = a;
    b2 = b;
    @(posedge clk);
    #1;
    q2.push_back('{d: {6'd0, ed}, bo: (a < b), k: cyc});
    start2 = 1'b0;
    a2 = ~a;
    b2 = ~b;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("busy2_idle", 32'(busy2), 32'd0);
    chk("done2_seen", 32'(q2.size()), 32'd0);
    q2.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_borrow8", 32'(bo8), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    go8(8'h5A, 8'h3C, 8'h1E, 1'b0);
    go8(8'h00, 8'h01, 8'hFF, 1'b1);
    go8(8'h80, 8'h80, 8'h00, 1'b0);

    // Hold start high for 30 edges. A new operation is accepted every 10
    // edges. The operands are disturbed mid-operation and restored before
    // the next accept.
    start8 = 1'b1;
    a8 = 8'h10;
    b8 = 8'h01;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i % 10 == 0) q8.push_back('{d: 8'h0F, bo: 1'b0, k: cyc});
      if (i % 10 == 3) begin
        a8 = 8'hFF;
        b8 = 8'hEE;
      end
      if (i % 10 == 8) begin
        a8 = 8'h10;
        b8 = 8'h01;
      end
    end
    start8 = 1'b0;
    chk("held_all_done", 32'(q8.size()), 32'd0);
    q8.delete();
    chk("held_idle", 32'(busy8), 32'd0);
    last_d8 = 8'h0F;
    last_b8 = 1'b0;

    // Abort mid-operation with reset. No done may follow.
    start8 = 1'b1;
    a8 = 8'hF0;
    b8 = 8'h0F;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_borrow", 32'(bo8), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_d8 = 8'h00;
    last_b8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(busy8), 32'd0);
    go8(8'hF0, 8'h0F, 8'hE1, 1'b0);

    // Back-to-back operations. 0xFE must hold throughout op2.
    go8(8'h03, 8'h05, 8'hFE, 1'b1);
    go8(8'h09, 8'h02, 8'h07, 1'b0);

    // Exhaustive test of the 2-bit instance.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        go2(2'(x), 2'(y));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
